mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that answers CPU-style rd/wr strobes
// with a fixed latency, a one-cycle ready pulse and a protocol-error pulse.
// Optional feature macro: MEM_RESPONDER_WAIT_EN
//   defined   -> WAIT state with a down-counter stretches every access.
//   undefined -> IDLE capture goes straight to DONE.
module mem_responder #(
    parameter int WAIT = 2,
    parameter int AW   = 5,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic          err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data
);

    localparam int DEPTH = 1 << AW;

`ifdef MEM_RESPONDER_WAIT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_REARM} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DONE, ST_REARM} state_t;
`endif

    state_t        state_reg, state_next;
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] rdata_reg;
    logic          err_reg, err_next;

    // Access performed on the coming edge (the edge that enters DONE)
    logic          access;
    logic          access_wr;
    logic [AW-1:0] access_addr;
    logic [DW-1:0] access_wdata;
    logic          preload;

    // Single memory write port shared by preload and CPU writes
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

`ifdef MEM_RESPONDER_WAIT_EN
    logic [3:0]    count_reg, count_next;
    logic          op_wr_reg, op_wr_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [DW-1:0] wdata_reg, wdata_next;
`endif

    // Next-state, capture and access-decode logic
    always_comb begin
        state_next   = state_reg;
        err_next     = 1'b0;
        access       = 1'b0;
        access_wr    = 1'b0;
        access_addr  = addr;
        access_wdata = wdata;
        preload      = 1'b0;
`ifdef MEM_RESPONDER_WAIT_EN
        count_next   = count_reg;
        op_wr_next   = op_wr_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ld_en) begin
                    // Preload owns the cycle; CPU strobes are not looked at
                    preload = 1'b1;
                end else if (rd && wr) begin
                    err_next   = 1'b1;
                    state_next = ST_REARM;
                end else if (rd || wr) begin
`ifdef MEM_RESPONDER_WAIT_EN
                    op_wr_next = wr;
                    addr_next  = addr;
                    wdata_next = wdata;
                    count_next = 4'(WAIT - 1);
                    state_next = ST_WAIT;
`else
                    access     = 1'b1;
                    access_wr  = wr;
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef MEM_RESPONDER_WAIT_EN
            ST_WAIT: begin
                if (op_wr_reg ? !wr : !rd) begin
                    // Requester gave up: drop the access silently
                    state_next = ST_IDLE;
                end else if (count_reg == 4'd0) begin
                    access       = 1'b1;
                    access_wr    = op_wr_reg;
                    access_addr  = addr_reg;
                    access_wdata = wdata_reg;
                    state_next   = ST_DONE;
                end else begin
                    count_next = count_reg - 4'd1;
                end
            end
`endif
            ST_DONE: begin
                state_next = ST_REARM;
            end
            ST_REARM: begin
                // Wait for both strobes low so a held strobe cannot retrigger
                if (!rd && !wr) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Memory write port mux; reset blocks any write in flight
    always_comb begin
        mem_we    = !rst && (preload || (access && access_wr));
        mem_waddr = preload ? ld_addr : access_addr;
        mem_wdata = preload ? ld_data : access_wdata;
    end

    // State, error pulse and registered read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (access && !access_wr) begin
                rdata_reg <= mem[access_addr];
            end
        end
    end

`ifdef MEM_RESPONDER_WAIT_EN
    // Captured request and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= 4'd0;
            op_wr_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            count_reg <= count_next;
            op_wr_reg <= op_wr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end
`endif

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rdata = rdata_reg;
    assign ready = (state_reg == ST_DONE);
    assign err   = err_reg;

endmodule
